// File: rtl/ex_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO; signed ops only when MULDIV_SIGNED_EN is defined.
// Latency: start -> done in DATA_WIDTH+1 cycles (divide by zero: 1 cycle); stall spans start..done.
// Backpressure: start is ignored while busy; flush aborts at any time without writing HI/LO.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           is_div;
    logic           div0;

    logic           idle;
    logic           launch;
    logic           div_by_zero;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;

    assign idle        = (state == IDLE);
    assign div_by_zero = op[1] && (b == '0);
    assign launch      = idle && start && !flush;
    assign stall       = busy | (start & idle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (launch) state_nxt = div_by_zero ? DONE : BUSY;
            BUSY: begin
                busy = 1'b1;
                if (flush)           state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = !flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MULDIV_SIGNED_EN
    logic sgn_a;
    logic sgn_b;
    logic neg_res;
    logic neg_rem;

    assign sgn_a = op[0] & a[W-1];
    assign sgn_b = op[0] & b[W-1];
    assign abs_a = sgn_a ? -a : a;
    assign abs_b = sgn_b ? -b : b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (launch) begin
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
        end
    end

    // Remainder follows the dividend; product and quotient follow the sign XOR.
    assign prod = neg_res ? -acc : acc;
    assign quot = neg_res ? -opa : opa;
    assign rem  = neg_rem ? -acc[W-1:0] : acc[W-1:0];
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign abs_a      = a;
    assign abs_b      = b;
    assign prod       = acc;
    assign quot       = opa;
    assign rem        = acc[W-1:0];
`endif

    // Restoring divide: partial remainder lives in acc[W-1:0], quotient shifts into opa.
    assign rem_sh = {acc[W-1:0], opa[W-1]};
    assign diff   = rem_sh - {1'b0, opb};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else if (launch) begin
            cnt    <= CW'(W - 1);
            acc    <= '0;
            opa    <= div_by_zero ? a : abs_a;
            opb    <= abs_b;
            is_div <= op[1];
            div0   <= div_by_zero;
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            if (!is_div) begin
                acc <= {acc[2*W-2:0], 1'b0} + (opb[W-1] ? {{W{1'b0}}, opa} : '0);
                opb <= {opb[W-2:0], 1'b0};
            end else begin
                acc <= {{W{1'b0}}, (diff[W] ? rem_sh[W-1:0] : diff[W-1:0])};
                opa <= {opa[W-2:0], ~diff[W]};
            end
        end
    end

    always_comb begin
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (is_div) begin
            if (div0) begin
                res_hi = opa;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == DONE && !flush) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, random ops against an arithmetic model,
// flush, ignored start, mid-operation reset and back-to-back issue.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, stall;
    logic [31:0] lo, hi;

    int nchk = 0;
    int nbad = 0;

    ex_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .stall(stall), .lo(lo), .hi(hi)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bit          sgn;
        longint      sx, sy;
        logic [63:0] q, m;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        if (!o[1]) return 64'(sx * sy);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = 64'(sx / sy);
        m = 64'(sx % sy);
        return {m[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    // Called at a negedge; issues one op and returns at the negedge after done (first IDLE cycle).
    task automatic launch_wait(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               output int lat, output int stall_cyc);
        op = o; a = x; b = y; start = 1'b1;
        lat = -1;
        stall_cyc = 0;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            #1;
            if (stall) stall_cyc++;
            if (done) lat = c;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        nchk++; if ({hi, lo} !== 64'd0) begin nbad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        nchk++; if ({busy, done, stall} !== 3'b000) begin nbad++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, stall}); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h0000_1234, 32'h8000_0000};
        logic [31:0] t_b  [6] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
`ifdef MULDIV_SIGNED_EN
        logic [63:0] t_exp[6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD,
                                  64'h0000_0002_0000_000E, 64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000};
`else
        logic [63:0] t_exp[6] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0006_FFFF_FFEB, 64'h0000_0001_7FFF_FFFC,
                                  64'h0000_0002_0000_000E, 64'h0000_1234_FFFF_FFFF, 64'h8000_0000_0000_0000};
`endif
        int lat, sc, exp_lat;
        for (int i = 0; i < 6; i++) begin
            exp_lat = (t_op[i][1] && t_b[i] == 32'd0) ? 1 : 33;
            launch_wait(t_op[i], t_a[i], t_b[i], lat, sc);
            nchk++; if (lat !== exp_lat) begin nbad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            nchk++; if (sc !== exp_lat + 1) begin nbad++; $display("FAIL dir%0d_stall_cycles: got %0d want %0d", i, sc, exp_lat + 1); end
            nchk++; if ({hi, lo} !== t_exp[i]) begin nbad++; $display("FAIL dir%0d_result: got %h want %h", i, {hi, lo}, t_exp[i]); end
            nchk++; if ({busy, done, stall} !== 3'b000) begin nbad++; $display("FAIL dir%0d_after_done: got %b want 000", i, {busy, done, stall}); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        int lat, sc, exp_lat, gap;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            exp = ref_result(o, x, y);
            exp_lat = (o[1] && y == 32'd0) ? 1 : 33;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            launch_wait(o, x, y, lat, sc);
            nchk++; if (lat !== exp_lat) begin nbad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            nchk++; if ({hi, lo} !== exp) begin nbad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, o, x, y, {hi, lo}, exp); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] prev;
        int lat, sc, seen;
        prev = ref_result(2'b00, 32'h8000_0000, 32'd4);
        launch_wait(2'b00, 32'h8000_0000, 32'd4, lat, sc);
        nchk++; if ({hi, lo} !== prev) begin nbad++; $display("FAIL flush_setup: got %h want %h", {hi, lo}, prev); end
        seen = 0;
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int c = 0; c < 11; c++) begin
            #1;
            if (done) seen++;
            @(negedge clk);
            start = 1'b0;
            flush = (c == 9);
        end
        flush = 1'b0;
        #1;
        nchk++; if (busy !== 1'b0) begin nbad++; $display("FAIL flush_idle: busy got %b want 0", busy); end
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        nchk++; if (busy !== 1'b0) begin nbad++; $display("FAIL flush_start_same_cycle: busy got %b want 0", busy); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (done) seen++;
        end
        nchk++; if (seen !== 0) begin nbad++; $display("FAIL flush_no_done: got %0d pulses want 0", seen); end
        nchk++; if ({hi, lo} !== prev) begin nbad++; $display("FAIL flush_hilo_kept: got %h want %h", {hi, lo}, prev); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        logic [31:0] x, y;
        logic [63:0] exp;
        int lat;
        x = $urandom();
        y = $urandom();
        exp = ref_result(2'b00, x, y);
        op = 2'b00; a = x; b = y; start = 1'b1;
        lat = -1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            #1;
            if (done) lat = c;
            @(negedge clk);
            start = (c == 4);
            if (c == 4) begin op = 2'b10; a = $urandom(); b = 32'd3; end
        end
        start = 1'b0;
        nchk++; if (lat !== 33) begin nbad++; $display("FAIL ignore_start_latency: got %0d want 33", lat); end
        nchk++; if ({hi, lo} !== exp) begin nbad++; $display("FAIL ignore_start_result: got %h want %h", {hi, lo}, exp); end
        #1;
        nchk++; if (busy !== 1'b0) begin nbad++; $display("FAIL ignore_start_idle: busy got %b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, sc;
        op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        nchk++; if (busy !== 1'b1) begin nbad++; $display("FAIL reset_mid_busy_before: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        nchk++; if ({hi, lo, busy, done, stall} !== 67'd0) begin nbad++; $display("FAIL reset_mid_outputs: got %h want 0", {hi, lo, busy, done, stall}); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        launch_wait(2'b00, 32'd2, 32'd3, lat, sc);
        nchk++; if (lat !== 33) begin nbad++; $display("FAIL reset_mid_relaunch_latency: got %0d want 33", lat); end
        nchk++; if ({hi, lo} !== 64'd6) begin nbad++; $display("FAIL reset_mid_relaunch_result: got %h want 6", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        int lat, sc, exp_lat;
        for (int i = 0; i < 4; i++) begin
            o = (i == 2) ? 2'b10 : 2'($urandom_range(0, 3));
            x = $urandom();
            y = (i == 2) ? 32'd0 : $urandom();
            exp = ref_result(o, x, y);
            exp_lat = (o[1] && y == 32'd0) ? 1 : 33;
            launch_wait(o, x, y, lat, sc);
            nchk++; if (lat !== exp_lat) begin nbad++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            nchk++; if ({hi, lo} !== exp) begin nbad++; $display("FAIL b2b%0d_result: got %h want %h", i, {hi, lo}, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end
endmodule
